jesd204b_dll_tx_ctrl: RTL

- Link-level sequencer for the JESD204B transmit path; sits between the transport mapper (driven via its enable) and the per-lane octet mux/8b10b stage.
- Runs the Code Group Sync / Initial Lane Alignment / Data state machine from the receiver's SYNC~ and SYSREF.
- Keeps the local multiframe clock (LMFC) counter.
- Emits select/flag signals telling the lane mux what to place in each frame.
- One frame per clk cycle: each clk carries OCTETS octets per lane.

---
 rtl/jesd204b_pkg.sv | 36 +++
 rtl/jesd204b_lmfc_cnt.sv | 49 ++++
 rtl/jesd204b_dll_tx_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/jesd204b_pkg.sv
// Shared encodings for the JESD204B transmit data-link layer: link states,
// lane-mux selects and the K-characters the lane mux inserts.
package jesd204b_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CGS  = 2'd1,
        ST_ILAS = 2'd2,
        ST_DATA = 2'd3
    } link_state_e;

    typedef enum logic [1:0] {
        MUX_ZERO  = 2'd0,
        MUX_KFILL = 2'd1,
        MUX_ILAS  = 2'd2,
        MUX_DATA  = 2'd3
    } mux_sel_e;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;

    // Each link state owns exactly one lane-mux source.
    function automatic mux_sel_e mux_for_state(input link_state_e st);
        mux_sel_e sel;
        case (st)
            ST_CGS:  sel = MUX_KFILL;
            ST_ILAS: sel = MUX_ILAS;
            ST_DATA: sel = MUX_DATA;
            default: sel = MUX_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/jesd204b_lmfc_cnt.sv
// Local multiframe clock: frame counter modulo FRAMES_PER_MF, realigned to 0
// by every SYSREF rising edge.
module jesd204b_lmfc_cnt
    import jesd204b_pkg::*;
#(
    parameter int FRAMES_PER_MF = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             sysref,
    output logic [$clog2(FRAMES_PER_MF)-1:0] lmfc_cnt,
    output logic [$clog2(FRAMES_PER_MF)-1:0] lmfc_cnt_nxt,
    output logic                             lmfc_last
);

    localparam int LW = $clog2(FRAMES_PER_MF);
    localparam logic [LW-1:0] LAST = LW'(FRAMES_PER_MF - 1);

    logic          sysref_q;
    logic          sysref_d;
    logic [LW-1:0] cnt_q;
    logic [LW-1:0] cnt_d;

    always_comb begin
        sysref_d = sysref;
        if (sysref && !sysref_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sysref_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sysref_q <= sysref_d;
            cnt_q    <= cnt_d;
        end
    end

    assign lmfc_cnt     = cnt_q;
    assign lmfc_cnt_nxt = cnt_d;
    assign lmfc_last    = (cnt_q == LAST);

endmodule

// File: rtl/jesd204b_dll_tx_ctrl.sv
// JESD204B transmit link sequencer: CGS / ILAS / DATA state machine driven by
// SYNC~ and the LMFC, with registered lane-mux selects and ILAS marker flags.
module jesd204b_dll_tx_ctrl
    import jesd204b_pkg::*;
#(
    parameter int OCTETS        = 4,
    parameter int FRAMES_PER_MF = 32,
    parameter int ILAS_MF       = 4,
    parameter int SYNC_REINIT   = 5,
    parameter int ERR_W         = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic                             sync_n,
    input  logic                             sysref,
    output logic [1:0]                       state,
    output logic                             tpl_en,
    output logic [1:0]                       mux_sel,
    output logic [$clog2(FRAMES_PER_MF)-1:0] lmfc_cnt,
    output logic [$clog2(ILAS_MF)-1:0]       ilas_mf,
    output logic                             ilas_r,
    output logic                             ilas_a,
    output logic                             ilas_q,
    output logic [ERR_W-1:0]                 sync_err_cnt
);

    localparam int LW = $clog2(FRAMES_PER_MF);
    localparam int MW = $clog2(ILAS_MF);
    localparam int RW = $clog2(SYNC_REINIT + 1);
    localparam logic [LW-1:0] LMFC_LAST = LW'(FRAMES_PER_MF - 1);
    localparam logic [MW-1:0] MF_LAST   = MW'(ILAS_MF - 1);
    localparam logic [RW-1:0] RUN_LAST  = RW'(SYNC_REINIT - 1);

    if (!(OCTETS == 1 || OCTETS == 2 || OCTETS == 4 || OCTETS == 8)) begin : g_bad_octets
        $error("OCTETS must be 1, 2, 4 or 8");
    end
    if (FRAMES_PER_MF < 4 || FRAMES_PER_MF > 32) begin : g_bad_k
        $error("FRAMES_PER_MF must be in 4..32");
    end
    if (ILAS_MF < 2 || SYNC_REINIT < 2) begin : g_bad_seq
        $error("ILAS_MF and SYNC_REINIT must be at least 2");
    end

    logic [LW-1:0] lmfc_cnt_w;
    logic [LW-1:0] lmfc_nxt_w;
    logic          lmfc_last_w;

    jesd204b_lmfc_cnt #(
        .FRAMES_PER_MF (FRAMES_PER_MF)
    ) u_lmfc (
        .clk          (clk),
        .reset        (reset),
        .sysref       (sysref),
        .lmfc_cnt     (lmfc_cnt_w),
        .lmfc_cnt_nxt (lmfc_nxt_w),
        .lmfc_last    (lmfc_last_w)
    );

    link_state_e    state_q,   state_d;
    logic [1:0]     mux_sel_q, mux_sel_d;
    logic           tpl_en_q,  tpl_en_d;
    logic [MW-1:0]  ilas_mf_q, ilas_mf_d;
    logic           ilas_r_q,  ilas_r_d;
    logic           ilas_a_q,  ilas_a_d;
    logic           ilas_q_q,  ilas_q_d;
    logic [RW-1:0]  run_q,     run_d;
    logic [ERR_W-1:0] err_q,   err_d;

    // Transitions are decided from the live LMFC so a SYSREF realignment
    // during CGS moves the ILAS start with it.
    always_comb begin
        state_d   = state_q;
        ilas_mf_d = ilas_mf_q;
        run_d     = '0;
        err_d     = err_q;

        if (!en) begin
            state_d   = ST_IDLE;
            ilas_mf_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CGS;
                end
                ST_CGS: begin
                    if (sync_n && lmfc_last_w) begin
                        state_d   = ST_ILAS;
                        ilas_mf_d = '0;
                    end
                end
                ST_ILAS: begin
                    if (!sync_n) begin
                        state_d   = ST_CGS;
                        ilas_mf_d = '0;
                    end else if (lmfc_last_w) begin
                        if (ilas_mf_q == MF_LAST) begin
                            state_d   = ST_DATA;
                            ilas_mf_d = '0;
                        end else begin
                            ilas_mf_d = ilas_mf_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (!sync_n) begin
                        if (run_q == RUN_LAST) begin
                            state_d = ST_CGS;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else if (run_q != '0 && err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Flags describe the frame that will be on the lanes after this edge.
        mux_sel_d = mux_for_state(state_d);
        tpl_en_d  = (state_d == ST_DATA);
        ilas_r_d  = (state_d == ST_ILAS) && (lmfc_nxt_w == '0);
        ilas_a_d  = (state_d == ST_ILAS) && (lmfc_nxt_w == LMFC_LAST);
        ilas_q_d  = (state_d == ST_ILAS) && (ilas_mf_d == MW'(1)) && (lmfc_nxt_w == LW'(1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mux_sel_q <= '0;
            tpl_en_q  <= 1'b0;
            ilas_mf_q <= '0;
            ilas_r_q  <= 1'b0;
            ilas_a_q  <= 1'b0;
            ilas_q_q  <= 1'b0;
            run_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            mux_sel_q <= mux_sel_d;
            tpl_en_q  <= tpl_en_d;
            ilas_mf_q <= ilas_mf_d;
            ilas_r_q  <= ilas_r_d;
            ilas_a_q  <= ilas_a_d;
            ilas_q_q  <= ilas_q_d;
            run_q     <= run_d;
            err_q     <= err_d;
        end
    end

    assign state        = state_q;
    assign mux_sel      = mux_sel_q;
    assign tpl_en       = tpl_en_q;
    assign lmfc_cnt     = lmfc_cnt_w;
    assign ilas_mf      = ilas_mf_q;
    assign ilas_r       = ilas_r_q;
    assign ilas_a       = ilas_a_q;
    assign ilas_q       = ilas_q_q;
    assign sync_err_cnt = err_q;

endmodule
